// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU-side types and constants.
// Holds the load-linked reservation entry layout, the channel limit for the
// link reservation table, and a helper that reduces an address to its line tag.
package cpu_types_pkg;

    localparam int unsigned LINK_MAX_CH   = 8;
    localparam int unsigned LINK_LINE_OFF = 2;
    localparam int unsigned LINK_CNT_W    = 8;
    localparam int unsigned LINK_TAG_W    = 32 - LINK_LINE_OFF;

    // One reservation as seen by debug/perf consumers.
    typedef struct packed {
        logic                  valid;
        logic [LINK_TAG_W-1:0] tag;
        logic [LINK_CNT_W-1:0] cnt;
    } link_entry_t;

    // Address to line tag: drop the low line_off bits that are ignored in matching.
    function automatic logic [LINK_TAG_W-1:0] link_line(input logic [31:0] addr,
                                                        input int unsigned line_off);
        return LINK_TAG_W'(addr >> line_off);
    endfunction

endpackage

// File: rtl/link_reservation_table_entry.sv
// link_entry: one load-linked reservation (valid, line tag, age counter).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   set             load the entry from req_line (takes precedence over clr)
//   clr             invalidate the entry
//   req_line        this channel's request line, used for set and SC compare
//   snoop_valid     a bus write is observed this cycle
//   snoop_line      line of the snooped write
//   valid, tag      registered entry state
//   addr_hit_c      entry valid and tag equals req_line
//   snoop_hit_c     snooped write hits this entry
//   expiring_c      entry times out on the coming edge
module link_entry #(
    parameter int unsigned LINE_OFF = 2,
    parameter int unsigned TIMEOUT  = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set,
    input  logic                 clr,
    input  logic [31-LINE_OFF:0] req_line,
    input  logic                 snoop_valid,
    input  logic [31-LINE_OFF:0] snoop_line,
    output logic                 valid,
    output logic [31-LINE_OFF:0] tag,
    output logic                 addr_hit_c,
    output logic                 snoop_hit_c,
    output logic                 expiring_c
);

    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Entry state; the age counter saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            cnt_q <= '0;
        end else if (set) begin
            valid <= 1'b1;
            tag   <= req_line;
            cnt_q <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            cnt_q <= '0;
        end else if (valid && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign addr_hit_c  = valid && (tag == req_line);
    assign snoop_hit_c = snoop_valid && valid && (tag == snoop_line);
    assign expiring_c  = (TIMEOUT != 0) && valid && (cnt_q == EXP_CNT);

endmodule

// File: rtl/link_reservation_table.sv
// link_reservation_table: per-channel LL/SC reservation table.
// Sets reservations on LL, resolves SC with fixed-priority arbitration among
// same-line SCs, and kills reservations on snooped writes, on successful SCs
// from other channels, on per-channel invalidate and on timeout.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   ll_req, sc_req       per-channel LL / SC strobes
//   addr_cpu             per-channel address, channel i at [32i+31:32i]
//   invalid              per-channel reservation clear
//   snoop_valid/addr     observed bus write
//   sc_done, sc_success  registered SC result, one cycle after sc_req
//   link_valid           registered reservation valid per channel
module link_reservation_table
    import cpu_types_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned LINE_OFF = 2,
    parameter int unsigned TIMEOUT  = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    ll_req,
    input  logic [NCH-1:0]    sc_req,
    input  logic [NCH*32-1:0] addr_cpu,
    input  logic [NCH-1:0]    invalid,
    input  logic              snoop_valid,
    input  logic [31:0]       snoop_addr,
    output logic [NCH-1:0]    sc_done,
    output logic [NCH-1:0]    sc_success,
    output logic [NCH-1:0]    link_valid
);

    localparam int unsigned TAG_W = 32 - LINE_OFF;

    logic [TAG_W-1:0] req_line [NCH];
    logic [TAG_W-1:0] ent_tag  [NCH];
    logic [TAG_W-1:0] snoop_line;
    logic [NCH-1:0]   ent_valid;
    logic [NCH-1:0]   addr_hit;
    logic [NCH-1:0]   snoop_hit;
    logic [NCH-1:0]   expiring;
    logic [NCH-1:0]   sc_cand;
    logic [NCH-1:0]   sc_win;
    logic [NCH-1:0]   xkill;
    logic [NCH-1:0]   ent_set;
    logic [NCH-1:0]   ent_clr;

    assign snoop_line = TAG_W'(link_line(snoop_addr, LINE_OFF));

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign req_line[g] = TAG_W'(link_line(addr_cpu[32*g +: 32], LINE_OFF));

        link_entry #(
            .LINE_OFF (LINE_OFF),
            .TIMEOUT  (TIMEOUT),
            .CNT_W    (CNT_W)
        ) u_entry (
            .clk         (CLK),
            .rst         (RST),
            .set         (ent_set[g]),
            .clr         (ent_clr[g]),
            .req_line    (req_line[g]),
            .snoop_valid (snoop_valid),
            .snoop_line  (snoop_line),
            .valid       (ent_valid[g]),
            .tag         (ent_tag[g]),
            .addr_hit_c  (addr_hit[g]),
            .snoop_hit_c (snoop_hit[g]),
            .expiring_c  (expiring[g])
        );
    end

    // SC arbitration, cross-channel kill and per-entry set/clear.
    always_comb begin
        sc_cand = '0;
        sc_win  = '0;
        xkill   = '0;
        ent_set = '0;
        ent_clr = '0;

        for (int i = 0; i < NCH; i++) begin
            sc_cand[i] = sc_req[i] && !invalid[i] && addr_hit[i]
                         && !snoop_hit[i] && !expiring[i];
        end

        // Lowest channel wins among passing SCs to the same line.
        for (int i = 0; i < NCH; i++) begin
            sc_win[i] = sc_cand[i];
            for (int j = 0; j < NCH; j++) begin
                if ((j < i) && sc_cand[j] && (req_line[j] == req_line[i])) begin
                    sc_win[i] = 1'b0;
                end
            end
        end

        // A winning SC is a store: it kills other reservations on its line.
        for (int k = 0; k < NCH; k++) begin
            for (int j = 0; j < NCH; j++) begin
                if ((j != k) && sc_win[j] && ent_valid[k] && (ent_tag[k] == req_line[j])) begin
                    xkill[k] = 1'b1;
                end
            end
        end

        // LL outranks snoop/kill/expiry but yields to invalidate and SC.
        for (int i = 0; i < NCH; i++) begin
            ent_set[i] = ll_req[i] && !sc_req[i] && !invalid[i];
            ent_clr[i] = invalid[i] || sc_req[i] || snoop_hit[i] || xkill[i] || expiring[i];
        end
    end

    // Registered SC result; reset drops any in-flight result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_done    <= '0;
            sc_success <= '0;
        end else begin
            sc_done    <= sc_req;
            sc_success <= sc_win;
        end
    end

    assign link_valid = ent_valid;

endmodule

// File: tb/tb_link_reservation_table.sv
// Bench for link_reservation_table: two instances fed the same stimulus
// (A: word lines, no timeout; B: 16-byte lines, timeout 4), checked every
// cycle against a reservation model, plus hand-computed directed cases.
module tb_link_reservation_table;

    localparam int NCH = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NCH-1:0]    ll_req;
    logic [NCH-1:0]    sc_req;
    logic [NCH-1:0]    invalid;
    logic [NCH*32-1:0] addr_cpu;
    logic              snoop_valid;
    logic [31:0]       snoop_addr;
    logic [NCH-1:0]    done_a, succ_a, lv_a;
    logic [NCH-1:0]    done_b, succ_b, lv_b;

    link_reservation_table #(.NCH(NCH), .LINE_OFF(2), .TIMEOUT(0), .CNT_W(8)) dut_a (
        .CLK(CLK), .RST(RST), .ll_req(ll_req), .sc_req(sc_req), .addr_cpu(addr_cpu),
        .invalid(invalid), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .sc_done(done_a), .sc_success(succ_a), .link_valid(lv_a));

    link_reservation_table #(.NCH(NCH), .LINE_OFF(4), .TIMEOUT(4), .CNT_W(8)) dut_b (
        .CLK(CLK), .RST(RST), .ll_req(ll_req), .sc_req(sc_req), .addr_cpu(addr_cpu),
        .invalid(invalid), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .sc_done(done_b), .sc_success(succ_b), .link_valid(lv_b));

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    // Reservation model: line number and the cycle the LL was taken.
    int unsigned m_off [2] = '{2, 4};
    int unsigned m_to  [2] = '{0, 4};
    bit          m_vld  [2][NCH];
    int unsigned m_line [2][NCH];
    longint      m_llc  [2][NCH];
    bit [NCH-1:0] m_done [2];
    bit [NCH-1:0] m_succ [2];
    bit [NCH-1:0] m_lv   [2];
    longint      cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input int d);
        bit          hit_s [NCH];
        bit          expd  [NCH];
        bit          cand  [NCH];
        bit          win   [NCH];
        bit          kill  [NCH];
        int unsigned al    [NCH];
        int unsigned sl;
        if (RST) begin
            for (int i = 0; i < NCH; i++) m_vld[d][i] = 1'b0;
            m_done[d] = '0;
            m_succ[d] = '0;
            m_lv[d]   = '0;
            return;
        end
        sl = snoop_addr >> m_off[d];
        for (int i = 0; i < NCH; i++) begin
            al[i]    = addr_cpu[32*i +: 32] >> m_off[d];
            hit_s[i] = snoop_valid && m_vld[d][i] && (m_line[d][i] == sl);
            expd[i]  = (m_to[d] != 0) && m_vld[d][i] && ((cyc - m_llc[d][i]) == longint'(m_to[d]));
            cand[i]  = sc_req[i] && !invalid[i] && m_vld[d][i] && (m_line[d][i] == al[i])
                       && !hit_s[i] && !expd[i];
        end
        for (int i = 0; i < NCH; i++) begin
            win[i] = cand[i];
            for (int j = 0; j < i; j++)
                if (cand[j] && (al[j] == al[i])) win[i] = 1'b0;
        end
        for (int k = 0; k < NCH; k++) begin
            kill[k] = 1'b0;
            for (int j = 0; j < NCH; j++)
                if ((j != k) && win[j] && m_vld[d][k] && (m_line[d][k] == al[j])) kill[k] = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
            m_done[d][i] = sc_req[i];
            m_succ[d][i] = win[i];
            if (invalid[i] || sc_req[i]) begin
                m_vld[d][i] = 1'b0;
            end else if (ll_req[i]) begin
                m_vld[d][i]  = 1'b1;
                m_line[d][i] = al[i];
                m_llc[d][i]  = cyc;
            end else if (hit_s[i] || kill[i] || expd[i]) begin
                m_vld[d][i] = 1'b0;
            end
            m_lv[d][i] = m_vld[d][i];
        end
    endtask

    always @(posedge CLK) begin
        model_step(0);
        model_step(1);
        cyc++;
    end

    task automatic cmp_dut(input int d, input logic [NCH-1:0] done, input logic [NCH-1:0] succ,
                           input logic [NCH-1:0] lv);
        chk($sformatf("dut%0d_sc_done", d), 32'(done), 32'(m_done[d]));
        chk($sformatf("dut%0d_link_valid", d), 32'(lv), 32'(m_lv[d]));
        for (int i = 0; i < NCH; i++)
            if (m_done[d][i]) chk($sformatf("dut%0d_sc_success%0d", d, i), 32'(succ[i]), 32'(m_succ[d][i]));
    endtask

    always @(negedge CLK) begin
        cmp_dut(0, done_a, succ_a, lv_a);
        cmp_dut(1, done_b, succ_b, lv_b);
    end

    task automatic idle();
        ll_req      = '0;
        sc_req      = '0;
        invalid     = '0;
        snoop_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_addr(input int ch, input logic [31:0] a);
        addr_cpu[32*ch +: 32] = a;
    endtask

    task automatic flush();
        idle();
        invalid = '1;
        tick();
        idle();
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        a = 32'h0000_0100 + 32'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
        return a;
    endfunction

    // LL ch0 @a, idle gap cycles, then SC ch0 @a; leaves outputs of the SC edge visible.
    task automatic ll_gap_sc(input logic [31:0] a, input int gap);
        idle(); set_addr(0, a); ll_req = 2'b01; tick();
        idle(); repeat (gap) tick();
        sc_req = 2'b01; tick();
    endtask

    initial begin
        RST = 1'b1;
        idle();
        addr_cpu   = '0;
        snoop_addr = '0;
        repeat (2) tick();
        chk("reset_a", 32'({done_a, succ_a, lv_a}), 32'h0);
        chk("reset_b", 32'({done_b, succ_b, lv_b}), 32'h0);
        RST = 1'b0;

        // LL, SC three cycles later: success on both, reservation consumed.
        ll_gap_sc(32'h100, 2);
        chk("basic_done_a", 32'(done_a), 32'h1);
        chk("basic_succ_a", 32'(succ_a[0]), 32'h1);
        chk("basic_lv_a", 32'(lv_a), 32'h0);
        chk("basic_succ_b", 32'(succ_b[0]), 32'h1);
        flush();

        // Snoop into the same word kills both.
        idle(); set_addr(0, 32'h100); ll_req = 2'b01; tick();
        idle(); snoop_valid = 1'b1; snoop_addr = 32'h102; tick();
        idle(); sc_req = 2'b01; tick();
        chk("snoop_word_succ_a", 32'(succ_a[0]), 32'h0);
        chk("snoop_word_succ_b", 32'(succ_b[0]), 32'h0);
        flush();

        // Snoop @0x10C: different word, same 16B line.
        idle(); set_addr(0, 32'h100); ll_req = 2'b01; tick();
        idle(); snoop_valid = 1'b1; snoop_addr = 32'h10C; tick();
        idle(); sc_req = 2'b01; tick();
        chk("snoop_line_succ_a", 32'(succ_a[0]), 32'h1);
        chk("snoop_line_succ_b", 32'(succ_b[0]), 32'h0);
        flush();

        // Snoop @0x110: next line for both.
        idle(); set_addr(0, 32'h100); ll_req = 2'b01; tick();
        idle(); snoop_valid = 1'b1; snoop_addr = 32'h110; tick();
        idle(); sc_req = 2'b01; tick();
        chk("snoop_other_succ_a", 32'(succ_a[0]), 32'h1);
        chk("snoop_other_succ_b", 32'(succ_b[0]), 32'h1);
        flush();

        // Two SCs to one line in the same cycle: channel 0 wins.
        idle(); set_addr(0, 32'h200); set_addr(1, 32'h200); ll_req = 2'b11; tick();
        idle(); sc_req = 2'b11; tick();
        chk("dual_done_a", 32'(done_a), 32'h3);
        chk("dual_succ_a", 32'(succ_a), 32'h1);
        chk("dual_lv_a", 32'(lv_a), 32'h0);
        chk("dual_succ_b", 32'(succ_b), 32'h1);
        flush();

        // SC ch1 succeeds and kills ch0's reservation on the same line.
        idle(); set_addr(0, 32'h300); set_addr(1, 32'h300); ll_req = 2'b11; tick();
        idle(); sc_req = 2'b10; tick();
        chk("xkill_succ_a", 32'(succ_a), 32'h2);
        chk("xkill_lv_a", 32'(lv_a), 32'h0);
        idle(); sc_req = 2'b01; tick();
        chk("xkill_late_succ_a", 32'(succ_a), 32'h0);
        chk("xkill_late_done_a", 32'(done_a), 32'h1);
        flush();

        // Timeout 4 on B: SC three cycles after LL passes, four cycles after fails.
        ll_gap_sc(32'h40, 2);
        chk("to3_succ_b", 32'(succ_b[0]), 32'h1);
        flush();
        ll_gap_sc(32'h40, 3);
        chk("to4_succ_b", 32'(succ_b[0]), 32'h0);
        chk("to4_done_b", 32'(done_b), 32'h1);
        chk("to4_lv_b", 32'(lv_b), 32'h0);
        chk("to4_succ_a", 32'(succ_a[0]), 32'h1);
        flush();

        // Reset during an SC: no done pulse, reservation gone afterwards.
        idle(); set_addr(1, 32'h80); ll_req = 2'b10; tick();
        idle(); sc_req = 2'b10; RST = 1'b1; tick();
        chk("rst_sc_a", 32'({done_a, succ_a, lv_a}), 32'h0);
        chk("rst_sc_b", 32'({done_b, succ_b, lv_b}), 32'h0);
        RST = 1'b0; idle(); sc_req = 2'b10; tick();
        chk("post_rst_done_a", 32'(done_a), 32'h2);
        chk("post_rst_succ_a", 32'(succ_a[1]), 32'h0);
        flush();

        // Randomised traffic over a small address pool.
        for (int n = 0; n < 3000; n++) begin
            RST = ($urandom_range(0, 199) == 0);
            for (int ch = 0; ch < NCH; ch++) begin
                ll_req[ch]  = ($urandom_range(0, 99) < 18);
                sc_req[ch]  = ($urandom_range(0, 99) < 12);
                invalid[ch] = ($urandom_range(0, 99) < 3);
                set_addr(ch, pick_addr());
            end
            snoop_valid = ($urandom_range(0, 99) < 8);
            snoop_addr  = pick_addr();
            tick();
        end
        RST = 1'b0;
        idle();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/link_reservation_table.md
Name: link_reservation_table

Overview:
- Parametrised successor to the single LL/SC link register: holds one load-linked reservation per channel (CPU core or hardware thread).
- Sits beside the dcache controllers.
- Sets reservations on LL, resolves SC success/failure, and snoops the coherence bus so that remote writes kill matching reservations.
- Adds multi-channel arbitration, line-granular matching and reservation timeout.

Parameters:
- NCH, 2, number of channels (1..8)
- LINE_OFF, 2, low address bits ignored in comparisons (2 = word, 3 = doubleword, 4 = 16B line)
- TIMEOUT, 0, cycles before a reservation self-expires; 0 disables expiry
- CNT_W, 8, width of each timeout counter (TIMEOUT < 2**CNT_W)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- ll_req  in  NCH  per-channel load-linked strobe, 1-cycle pulse
- sc_req  in  NCH  per-channel store-conditional strobe, 1-cycle pulse
- addr_cpu  in  NCH*32  per-channel address; channel i occupies bits [32i+31:32i]
- invalid  in  NCH  per-channel clear (exception/ERET/context switch)
- snoop_valid  in  1  bus write/invalidate observed this cycle
- snoop_addr  in  32  address of the snooped write
- sc_done  out  NCH  SC result valid, registered, 1-cycle pulse
- sc_success  out  NCH  SC outcome; meaningful only while sc_done is high
- link_valid  out  NCH  current reservation valid per channel (debug/perf)

Behaviour:
- Reset: all entries invalid, counters 0; sc_done, sc_success and link_valid all 0. Reset applies on the first CLK edge with RST=1 and aborts any in-flight SC (no sc_done is produced).
- Match rule: addresses match when addr[31:LINE_OFF] bits are equal.
- LL on channel i: next cycle, entry i is {valid=1, tag=addr_cpu_i[31:LINE_OFF]} and counter i = 0. Any previous reservation on channel i is overwritten.
- SC on channel i:
  - Evaluated combinationally against the entry state before this edge.
  - Result is registered: sc_done_i is high exactly 1 cycle after sc_req_i (latency 1).
  - Success requires: entry valid, tag match, no killing event in the same cycle, and arbitration won.
  - Entry i is cleared after any SC, whether it passes or fails.
- Successful SC from channel i clears every other channel whose tag matches (the store is a write).
- Snoop: snoop_valid with a matching tag clears all matching entries next cycle.
- invalid_i clears entry i next cycle.
- Timeout (TIMEOUT>0):
  - Counter increments each cycle while its entry is valid.
  - When the counter equals TIMEOUT-1, the entry clears on that edge.
  - An SC in the expiring cycle fails.
  - Counter saturates; it never wraps.
- Same-cycle priority, per channel, highest first:
  1. RST
  2. invalid_i (kills LL and SC: SC fails, LL ignored)
  3. snoop match (SC fails)
  4. sc_req_i (an ll_req_i asserted in the same cycle is ignored)
  5. ll_req_i
- LL vs snoop, same cycle, same line: LL wins and the entry ends valid. The load returns post-write data, so the reservation is coherent.
- Multiple SCs in one cycle to the same line, all otherwise passing: lowest channel index succeeds; the others fail and their entries clear.
- SCs to different lines in the same cycle are independent.
- link_valid is the registered entry valid bit. No combinational input-to-output path exists.

Decomposition:
- cpu_types_pkg gains:
  - typedef link_entry_t: struct {logic valid; logic [31-LINE_OFF:0] tag; logic [CNT_W-1:0] cnt}, tag sized by package constant LINK_LINE_OFF
  - localparam LINK_MAX_CH = 8
- Sub-module link_entry: one per channel, via generate. Holds valid/tag/counter, does the match compare, and takes one-hot set/clear inputs.
- Top level performs SC arbitration (fixed priority) and cross-channel kill.
- link_module_if is extended into an NCH-parametrised interface with modport lrt.

Test Plan:
- NCH=2, LINE_OFF=2: LL ch0 @0x100; 3 cycles later SC ch0 @0x100 -> next cycle sc_done[0]=1, sc_success[0]=1, link_valid[0]=0.
- LL ch0 @0x100, then snoop_valid @0x102, then SC ch0 @0x100 -> sc_success[0]=0. Repeat with LINE_OFF=4 and snoop @0x10C -> also fails. Snoop @0x110 -> SC succeeds.
- LL ch0 and LL ch1 both @0x200; same cycle SC ch0 and SC ch1 @0x200 -> sc_success = 2'b01, both entries cleared.
- LL ch0 @0x300 and LL ch1 @0x300; SC ch1 succeeds -> link_valid[0]=0 next cycle; later SC ch0 @0x300 -> fail.
- TIMEOUT=4: LL ch0 @0x40; SC issued 3 cycles later -> success. SC issued 4 cycles later -> fail, with link_valid[0] already 0.
- LL ch1 @0x80; assert RST one cycle while an SC ch1 is pending -> no sc_done pulse; all outputs 0. Post-reset SC ch1 @0x80 -> fail.
